// File: rtl/lvds_video_pkg.sv
`default_nettype none
// ==========================================================================
// Module : lvds_video_pkg
// Brief  : shared types, default 1366x768 timing and parameter checks
// Rev    : 1.0  initial release
// ==========================================================================
package lvds_video_pkg;

   typedef logic [23:0] rgb_t;

   localparam int DEF_H_ACTIVE = 1366;
   localparam int DEF_H_FP     = 14;
   localparam int DEF_H_SYNC   = 16;
   localparam int DEF_H_BP     = 20;
   localparam int DEF_V_ACTIVE = 768;
   localparam int DEF_V_FP     = 3;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 3;

   // h/v counters are CNT_W wide; window bound sums need one extra bit
   localparam int CNT_W          = 12;
   localparam int CMP_W          = CNT_W + 1;
   localparam int MAX_SCALE_LOG2 = 3;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic inwin;
      logic fs;
   } ctl_t;

   function automatic int timing_total(input int active, input int fp,
                                       input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic bit scale_log2_legal(input int s);
      return (s >= 0) && (s <= MAX_SCALE_LOG2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_window_addr_gen.sv
`default_nettype none
// ==========================================================================
// Module : lvds_window_addr_gen
// Brief  : incremental image-RAM address walk for a 2^SCALE_LOG2 window
// Rev    : 1.0  initial release
// ==========================================================================
module lvds_window_addr_gen
   import lvds_video_pkg::*;
#(
   parameter int WIN_W_SRC  = 100,
   parameter int WIN_H_SRC  = 100,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 14
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  h,
   input  logic [CNT_W-1:0]  v,
   input  logic              de,
   input  logic              first_pixel,
   input  logic              line_end,
   input  logic              frame_end,
   input  logic [10:0]       win_x0,
   input  logic [10:0]       win_y0,
   output logic              inwin,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [CMP_W-1:0]  c_win_w    = CMP_W'(WIN_W_SRC << SCALE_LOG2);
   localparam logic [CMP_W-1:0]  c_win_h    = CMP_W'(WIN_H_SRC << SCALE_LOG2);
   localparam logic [2:0]        c_rep_m1   = 3'((1 << SCALE_LOG2) - 1);
   localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(WIN_W_SRC);

   logic [10:0]       r_wx0, r_wy0;
   logic [10:0]       w_wx0, w_wy0;
   logic [2:0]        r_xr, r_yr;
   logic [ADDR_W-1:0] r_col, r_row_base;
   logic [CMP_W-1:0]  w_x_lo, w_x_hi, w_y_lo, w_y_hi, w_h, w_v;
   logic              w_col_in, w_row_in;

   // Pixel (0,0) already belongs to the new frame, so it sees the live origin
   assign w_wx0 = first_pixel ? win_x0 : r_wx0;
   assign w_wy0 = first_pixel ? win_y0 : r_wy0;

   assign w_x_lo = CMP_W'(w_wx0);
   assign w_x_hi = w_x_lo + c_win_w;
   assign w_y_lo = CMP_W'(w_wy0);
   assign w_y_hi = w_y_lo + c_win_h;
   assign w_h    = CMP_W'(h);
   assign w_v    = CMP_W'(v);

   assign w_col_in = (w_h >= w_x_lo) && (w_h < w_x_hi);
   assign w_row_in = (w_v >= w_y_lo) && (w_v < w_y_hi);
   assign inwin    = de && w_col_in && w_row_in;
   assign addr     = r_row_base + r_col;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wx0      <= '0;
         r_wy0      <= '0;
         r_xr       <= '0;
         r_yr       <= '0;
         r_col      <= '0;
         r_row_base <= '0;
      end else begin
         if (first_pixel) begin
            r_wx0 <= win_x0;
            r_wy0 <= win_y0;
         end
         // Row stepping keys off the window rows only, so right clipping
         // (which merely stops col early) never disturbs row_base.
         if (line_end) begin
            r_xr  <= '0;
            r_col <= '0;
            if (frame_end) begin
               r_yr       <= '0;
               r_row_base <= '0;
            end else if (w_row_in) begin
               if (r_yr == c_rep_m1) begin
                  r_yr       <= '0;
                  r_row_base <= r_row_base + c_row_step;
               end else begin
                  r_yr <= r_yr + 3'd1;
               end
            end
         end else if (inwin) begin
            if (r_xr == c_rep_m1) begin
               r_xr  <= '0;
               r_col <= r_col + ADDR_W'(1);
            end else begin
               r_xr <= r_xr + 3'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lvds_video_timing_window.sv
`default_nettype none
// ==========================================================================
// Module : lvds_video_timing_window
// Brief  : panel timing, scaled window fetch and RAM-latency matched mux
// Rev    : 1.0  initial release
// ==========================================================================
module lvds_video_timing_window
   import lvds_video_pkg::*;
#(
   parameter int   H_ACTIVE   = DEF_H_ACTIVE,
   parameter int   H_FP       = DEF_H_FP,
   parameter int   H_SYNC     = DEF_H_SYNC,
   parameter int   H_BP       = DEF_H_BP,
   parameter int   V_ACTIVE   = DEF_V_ACTIVE,
   parameter int   V_FP       = DEF_V_FP,
   parameter int   V_SYNC     = DEF_V_SYNC,
   parameter int   V_BP       = DEF_V_BP,
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   WIN_W_SRC  = 100,
   parameter int   WIN_H_SRC  = 100,
   parameter int   SCALE_LOG2 = 2,
   parameter int   ADDR_W     = 14,
   parameter int   RAM_LAT    = 1,
   parameter rgb_t BG_RGB     = 24'h000000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [10:0]       win_x0,
   input  logic [10:0]       win_y0,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [23:0]       rgb_in,
   output logic [23:0]       rgb_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              de_out,
   output logic              frame_start
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] c_hs_start = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] c_vs_start = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (!scale_log2_legal(SCALE_LOG2)) begin : g_bad_scale
      $error("SCALE_LOG2 must be in 0..3");
   end
   if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
      $error("RAM_LAT must be in 1..4");
   end
   if (WIN_W_SRC * WIN_H_SRC > (1 << ADDR_W)) begin : g_bad_addr
      $error("source image does not fit in ADDR_W");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
      $error("timing totals exceed counter width");
   end

   logic [CNT_W-1:0]  r_h, r_v;
   logic              w_clear, w_first, w_line_end, w_frame_end;
   logic              w_de, w_hs, w_vs, w_inwin;
   logic [ADDR_W-1:0] w_addr;
   ctl_t              r_pipe [0:RAM_LAT];

   assign w_clear     = rst || !enable;
   assign w_first     = (r_h == '0) && (r_v == '0);
   assign w_line_end  = (r_h == c_h_last);
   assign w_frame_end = w_line_end && (r_v == c_v_last);
   assign w_de        = (r_h < c_h_act) && (r_v < c_v_act);
   assign w_hs        = (r_h >= c_hs_start) && (r_h < c_hs_end);
   assign w_vs        = (r_v >= c_vs_start) && (r_v < c_vs_end);

   lvds_window_addr_gen #(
      .WIN_W_SRC  (WIN_W_SRC),
      .WIN_H_SRC  (WIN_H_SRC),
      .SCALE_LOG2 (SCALE_LOG2),
      .ADDR_W     (ADDR_W)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (w_clear),
      .h           (r_h),
      .v           (r_v),
      .de          (w_de),
      .first_pixel (w_first),
      .line_end    (w_line_end),
      .frame_end   (w_frame_end),
      .win_x0      (win_x0),
      .win_y0      (win_y0),
      .inwin       (w_inwin),
      .addr        (w_addr)
   );

   // r_pipe[0] is the decode stage; r_pipe[RAM_LAT] lines up with rgb_in
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_h         <= '0;
         r_v         <= '0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         for (int i = 0; i <= RAM_LAT; i++) r_pipe[i] <= '0;
         rgb_out     <= '0;
         de_out      <= 1'b0;
         hsync_out   <= ~HS_POL;
         vsync_out   <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         if (w_line_end) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + CNT_W'(1);
         end else begin
            r_h <= r_h + CNT_W'(1);
         end

         r_pipe[0] <= '{de: w_de, hs: w_hs, vs: w_vs, inwin: w_inwin, fs: w_first};
         for (int i = 1; i <= RAM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
         rd_en   <= w_inwin;
         rd_addr <= w_addr;

         de_out      <= r_pipe[RAM_LAT].de;
         hsync_out   <= r_pipe[RAM_LAT].hs ? HS_POL : ~HS_POL;
         vsync_out   <= r_pipe[RAM_LAT].vs ? VS_POL : ~VS_POL;
         frame_start <= r_pipe[RAM_LAT].fs;
         if (!r_pipe[RAM_LAT].de)
            rgb_out <= '0;
         else if (r_pipe[RAM_LAT].inwin)
            rgb_out <= rgb_in;
         else
            rgb_out <= BG_RGB;
      end
   end

endmodule
`default_nettype wire
